// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned NUM_CLIENTS = 3;
   localparam int unsigned RUN_W       = 4;
   localparam int unsigned TMO_W       = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLI_CHR  = 2'd0,
      CLI_PRG  = 2'd1,
      CLI_WRAM = 2'd2
   } client_t;

   // One-hot grant to client id; an empty grant maps to CHR and is never used.
   function automatic client_t grant_to_client(input logic [NUM_CLIENTS-1:0] grant);
      client_t c;
      c = CLI_CHR;
      if (grant[1]) c = CLI_PRG;
      else if (grant[2]) c = CLI_WRAM;
      return c;
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection: CHR priority with run limit, PRG/WRAM round-robin.
module mem_arb_select
   import mem_arb_pkg::*;
#(
   parameter int unsigned CHR_MAX_RUN = 4
) (
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [RUN_W-1:0]       run_cnt,
   input  client_t                rr_ptr,
   output logic [NUM_CLIENTS-1:0] grant_c
);

   logic others_c;
   logic chr_ok_c;

   assign others_c = req[1] | req[2];
   // CHR is only masked when it has used up its run and someone else is waiting.
   assign chr_ok_c = req[0] & (~others_c | (run_cnt < RUN_W'(CHR_MAX_RUN)));

   // Pick exactly one winner, or none.
   always_comb begin
      grant_c = '0;
      if (chr_ok_c) begin
         grant_c = 3'b001;
      end else if (req[1] && req[2]) begin
         grant_c = (rr_ptr == CLI_WRAM) ? 3'b100 : 3'b010;
      end else if (req[1]) begin
         grant_c = 3'b010;
      end else if (req[2]) begin
         grant_c = 3'b100;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller port between CHR, PRG and WRAM requesters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned CHR_MAX_RUN = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic              clk_mem,
   input  logic              rst,
   input  logic              chr_req,
   input  logic [ADDR_W-1:0] chr_addr,
   output logic              chr_done,
   output logic [DATA_W-1:0] chr_rdata,
   input  logic              prg_req,
   input  logic [ADDR_W-1:0] prg_addr,
   output logic              prg_done,
   output logic [DATA_W-1:0] prg_rdata,
   input  logic              wram_req,
   input  logic              wram_wren,
   input  logic [ADDR_W-1:0] wram_addr,
   input  logic [DATA_W-1:0] wram_wdata,
   output logic              wram_done,
   output logic [DATA_W-1:0] wram_rdata,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_to_mem,
   output logic              mem_wren,
   output logic              mem_req,
   input  logic [DATA_W-1:0] mem_from_mem,
   input  logic              mem_ready
);

   state_t                 state_q, state_d;
   client_t                owner_q, owner_d;
   client_t                rr_q, rr_d;
   logic [RUN_W-1:0]       run_q, run_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [ADDR_W-1:0]      mem_address_q, mem_address_d;
   logic [DATA_W-1:0]      mem_to_mem_q, mem_to_mem_d;
   logic                   mem_wren_q, mem_wren_d;
   logic                   mem_req_q, mem_req_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic [NUM_CLIENTS-1:0] done_q, done_d;
   logic [DATA_W-1:0]      chr_rdata_q, chr_rdata_d;
   logic [DATA_W-1:0]      prg_rdata_q, prg_rdata_d;
   logic [DATA_W-1:0]      wram_rdata_q, wram_rdata_d;
   logic [NUM_CLIENTS-1:0] grant_c;

   mem_arb_select #(
      .CHR_MAX_RUN (CHR_MAX_RUN)
   ) u_select (
      .req     ({wram_req, prg_req, chr_req}),
      .run_cnt (run_q),
      .rr_ptr  (rr_q),
      .grant_c (grant_c)
   );

   // Next-state, latching and pulse generation.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_d          = rr_q;
      run_d         = run_q;
      tmo_d         = tmo_q;
      mem_address_d = mem_address_q;
      mem_to_mem_d  = mem_to_mem_q;
      mem_wren_d    = mem_wren_q;
      chr_rdata_d   = chr_rdata_q;
      prg_rdata_d   = prg_rdata_q;
      wram_rdata_d  = wram_rdata_q;
      mem_req_d     = 1'b0;
      err_d         = 1'b0;
      done_d        = '0;
      busy_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|grant_c) begin
               state_d   = ST_ISSUE;
               mem_req_d = 1'b1;
               owner_d   = grant_to_client(grant_c);
               if (grant_c[0]) begin
                  mem_address_d = chr_addr;
                  mem_to_mem_d  = '0;
                  mem_wren_d    = 1'b0;
                  run_d         = (prg_req | wram_req) ? run_q + RUN_W'(1) : '0;
               end else if (grant_c[1]) begin
                  mem_address_d = prg_addr;
                  mem_to_mem_d  = '0;
                  mem_wren_d    = 1'b0;
                  run_d         = '0;
                  rr_d          = CLI_WRAM;
               end else begin
                  mem_address_d = wram_addr;
                  mem_to_mem_d  = wram_wdata;
                  mem_wren_d    = wram_wren;
                  run_d         = '0;
                  rr_d          = CLI_PRG;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            tmo_d   = '0;
         end
         ST_WAIT: begin
            if (mem_ready) begin
               state_d = ST_RESP;
               done_d  = NUM_CLIENTS'(1) << owner_q;
               if (!mem_wren_q) begin
                  case (owner_q)
                     CLI_CHR:  chr_rdata_d  = mem_from_mem;
                     CLI_PRG:  prg_rdata_d  = mem_from_mem;
                     CLI_WRAM: wram_rdata_d = mem_from_mem;
                     default:  ;
                  endcase
               end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d = ST_RESP;
               done_d  = NUM_CLIENTS'(1) << owner_q;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk_mem) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= CLI_CHR;
         rr_q          <= CLI_PRG;
         run_q         <= '0;
         tmo_q         <= '0;
         mem_address_q <= '0;
         mem_to_mem_q  <= '0;
         mem_wren_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         done_q        <= '0;
         chr_rdata_q   <= '0;
         prg_rdata_q   <= '0;
         wram_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_q          <= rr_d;
         run_q         <= run_d;
         tmo_q         <= tmo_d;
         mem_address_q <= mem_address_d;
         mem_to_mem_q  <= mem_to_mem_d;
         mem_wren_q    <= mem_wren_d;
         mem_req_q     <= mem_req_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
         done_q        <= done_d;
         chr_rdata_q   <= chr_rdata_d;
         prg_rdata_q   <= prg_rdata_d;
         wram_rdata_q  <= wram_rdata_d;
      end
   end

   assign chr_done    = done_q[0];
   assign prg_done    = done_q[1];
   assign wram_done   = done_q[2];
   assign chr_rdata   = chr_rdata_q;
   assign prg_rdata   = prg_rdata_q;
   assign wram_rdata  = wram_rdata_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign mem_address = mem_address_q;
   assign mem_to_mem  = mem_to_mem_q;
   assign mem_wren    = mem_wren_q;
   assign mem_req     = mem_req_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model, controller responder, directed scenarios.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W      = 23;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned CHR_MAX_RUN = 4;
   localparam int unsigned TIMEOUT     = 255;

   logic              clk_mem    = 1'b0;
   logic              rst        = 1'b1;
   logic              chr_req    = 1'b0;
   logic [ADDR_W-1:0] chr_addr   = '0;
   logic              chr_done;
   logic [DATA_W-1:0] chr_rdata;
   logic              prg_req    = 1'b0;
   logic [ADDR_W-1:0] prg_addr   = '0;
   logic              prg_done;
   logic [DATA_W-1:0] prg_rdata;
   logic              wram_req   = 1'b0;
   logic              wram_wren  = 1'b0;
   logic [ADDR_W-1:0] wram_addr  = '0;
   logic [DATA_W-1:0] wram_wdata = '0;
   logic              wram_done;
   logic [DATA_W-1:0] wram_rdata;
   logic              err;
   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_to_mem;
   logic              mem_wren;
   logic              mem_req;
   logic [DATA_W-1:0] mem_from_mem = '0;
   logic              mem_ready    = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   mem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .CHR_MAX_RUN (CHR_MAX_RUN),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk_mem      (clk_mem),
      .rst          (rst),
      .chr_req      (chr_req),
      .chr_addr     (chr_addr),
      .chr_done     (chr_done),
      .chr_rdata    (chr_rdata),
      .prg_req      (prg_req),
      .prg_addr     (prg_addr),
      .prg_done     (prg_done),
      .prg_rdata    (prg_rdata),
      .wram_req     (wram_req),
      .wram_wren    (wram_wren),
      .wram_addr    (wram_addr),
      .wram_wdata   (wram_wdata),
      .wram_done    (wram_done),
      .wram_rdata   (wram_rdata),
      .err          (err),
      .busy         (busy),
      .mem_address  (mem_address),
      .mem_to_mem   (mem_to_mem),
      .mem_wren     (mem_wren),
      .mem_req      (mem_req),
      .mem_from_mem (mem_from_mem),
      .mem_ready    (mem_ready)
   );

   always #5 clk_mem = ~clk_mem;

   always @(posedge clk_mem) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
   endtask

   // Controller stand-in: answers resp_lat cycles after mem_req (0 = never), plus stray pulses.
   int          resp_lat     = 1;
   logic [15:0] rd_word      = '0;
   bit          vary         = 1'b0;
   int          stray_req_n  = 0;
   int          stray_done_n = 0;

   initial begin : responder
      int   cd = 0;
      int   n_resp = 0;
      logic seen;
      forever begin
         @(negedge clk_mem);
         seen = mem_req;
         @(posedge clk_mem);
         #1;
         mem_ready = 1'b0;
         if (rst) begin
            cd = 0;
         end else begin
            if (seen && resp_lat > 0) cd = resp_lat;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  mem_ready    = 1'b1;
                  mem_from_mem = vary ? rd_word + 16'(n_resp) : rd_word;
                  n_resp++;
               end
            end else if (stray_done_n != stray_req_n) begin
               stray_done_n++;
               mem_ready    = 1'b1;
               mem_from_mem = 16'hDEAD;
            end
         end
      end
   end

   // Transaction-level reference: one job at a time, expected outputs for the cycle after each edge.
   bit          m_valid = 0, m_act = 0, m_in_wait = 0, m_resp = 0, m_wren = 0;
   int          m_owner = 0, m_waits = 0, m_run = 0, m_rr = 1;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [DATA_W-1:0] m_wdata = '0;
   logic [DATA_W-1:0] m_rd [3];
   logic [2:0]  e_done = '0;
   bit          e_err = 0, e_mreq = 0, e_busy = 0;

   always @(posedge clk_mem) begin
      int  w;
      bit  oth;
      if (rst) begin
         m_valid = 1; m_act = 0; m_in_wait = 0; m_resp = 0; m_wren = 0;
         m_run = 0; m_rr = 1; m_addr = '0; m_wdata = '0;
         for (int k = 0; k < 3; k++) m_rd[k] = '0;
         e_done = '0; e_err = 0; e_mreq = 0; e_busy = 0;
      end else if (m_valid) begin
         e_done = '0; e_err = 0; e_mreq = 0;
         if (m_resp) begin
            m_resp = 0;
            m_act  = 0;
         end else if (!m_act) begin
            w   = -1;
            oth = prg_req || wram_req;
            if (chr_req && (m_run < CHR_MAX_RUN || !oth)) begin
               w     = 0;
               m_run = oth ? m_run + 1 : 0;
            end else if (prg_req && wram_req) w = m_rr;
            else if (prg_req) w = 1;
            else if (wram_req) w = 2;
            if (w > 0) begin
               m_run = 0;
               m_rr  = 3 - w;
            end
            if (w >= 0) begin
               m_act = 1; m_in_wait = 0; m_owner = w; e_mreq = 1;
               m_addr = (w == 0) ? chr_addr : (w == 1) ? prg_addr : wram_addr;
               m_wren = (w == 2) && wram_wren;
               if (m_wren) m_wdata = wram_wdata;
            end
         end else if (!m_in_wait) begin
            m_in_wait = 1;
            m_waits   = 0;
         end else if (mem_ready) begin
            if (!m_wren) m_rd[m_owner] = mem_from_mem;
            e_done[m_owner] = 1'b1;
            m_resp = 1;
         end else begin
            m_waits++;
            if (m_waits == TIMEOUT) begin
               e_done[m_owner] = 1'b1;
               e_err  = 1;
               m_resp = 1;
            end
         end
         e_busy = m_act;
      end
   end

   // Every-cycle comparison against the reference.
   always @(negedge clk_mem) begin
      if (m_valid) begin
         chk("chr_done",   chr_done,    e_done[0]);
         chk("prg_done",   prg_done,    e_done[1]);
         chk("wram_done",  wram_done,   e_done[2]);
         chk("err",        err,         e_err);
         chk("busy",       busy,        e_busy);
         chk("mem_req",    mem_req,     e_mreq);
         chk("mem_wren",   mem_wren,    m_wren);
         chk("mem_address", mem_address, m_addr);
         chk("chr_rdata",  chr_rdata,   m_rd[0]);
         chk("prg_rdata",  prg_rdata,   m_rd[1]);
         chk("wram_rdata", wram_rdata,  m_rd[2]);
         if (m_wren) chk("mem_to_mem", mem_to_mem, m_wdata);
      end
   end

   task automatic step();
      @(posedge clk_mem);
      #1;
   endtask

   task automatic wait_mreq(input string nm, output int at);
      bit hit = 0;
      at = -1;
      for (int i = 0; i < 50 && !hit; i++) begin
         @(negedge clk_mem);
         if (mem_req) begin hit = 1; at = cyc; end
      end
      if (!hit) bound_fail(nm);
   endtask

   task automatic wait_done(input string nm, input int k, input int budget, output int at);
      bit         hit = 0;
      logic [2:0] dv;
      at = -1;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk_mem);
         dv = {wram_done, prg_done, chr_done};
         if (dv[k]) begin hit = 1; at = cyc; end
      end
      if (!hit) bound_fail(nm);
   endtask

   task automatic wait_any_done(output int who);
      bit hit = 0;
      who = -1;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk_mem);
         if (chr_done)       begin hit = 1; who = 0; end
         else if (prg_done)  begin hit = 1; who = 1; end
         else if (wram_done) begin hit = 1; who = 2; end
      end
      if (!hit) bound_fail("any_done");
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int c0, t0, t1, nd, nb, who;
      int got [10];
      int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};

      repeat (3) step();
      rst = 1'b0;
      @(negedge clk_mem);
      chk("reset_busy",     busy,        0);
      chk("reset_mem_addr", mem_address, 0);
      chk("reset_to_mem",   mem_to_mem,  0);
      chk("reset_chr_rd",   chr_rdata,   0);

      // Single CHR read, controller answers in the first WAIT cycle.
      step();
      resp_lat = 1; rd_word = 16'hBEEF;
      chr_addr = 23'h000123; chr_req = 1'b1;
      c0 = cyc;
      wait_mreq("t1_mreq", t0);
      chk("t1_mreq_lat", t0 - c0, 1);
      chk("t1_addr", mem_address, 23'h000123);
      chk("t1_wren", mem_wren, 0);
      wait_done("t1_done", 0, 50, t1);
      chk("t1_done_lat", t1 - c0, 3);
      step();
      chr_req = 1'b0;
      chk("t1_rdata", chr_rdata, 16'hBEEF);

      // WRAM write leaves wram_rdata untouched.
      step();
      wram_wren = 1'b1; wram_addr = 23'h400010; wram_wdata = 16'h5A5A; wram_req = 1'b1;
      wait_mreq("t2_mreq", t0);
      chk("t2_wren",   mem_wren,   1);
      chk("t2_wdata",  mem_to_mem, 16'h5A5A);
      chk("t2_addr",   mem_address, 23'h400010);
      wait_done("t2_done", 2, 50, t1);
      step();
      wram_req = 1'b0; wram_wren = 1'b0;
      chk("t2_rdata", wram_rdata, 0);

      // All three held: CHR run limit and PRG/WRAM alternation.
      step();
      vary = 1'b1; rd_word = 16'h1000;
      chr_addr = 23'h000011; prg_addr = 23'h000022; wram_addr = 23'h000033;
      chr_req = 1'b1; prg_req = 1'b1; wram_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_any_done(who);
         got[i] = who;
      end
      step();
      chr_req = 1'b0; prg_req = 1'b0; wram_req = 1'b0;
      vary = 1'b0;
      for (int i = 0; i < 10; i++) chk($sformatf("t3_order_%0d", i), 64'(got[i]), 64'(exp_order[i]));

      // Controller never answers: watchdog abort.
      step();
      resp_lat = 0;
      prg_addr = 23'h0ABCDE; prg_req = 1'b1;
      wait_mreq("t4_mreq", t0);
      wait_done("t4_done", 1, 1000, t1);
      chk("t4_timeout_len", t1 - t0, 256);
      chk("t4_err", err, 1);
      step();
      prg_req = 1'b0; resp_lat = 1; rd_word = 16'h1234;
      step();
      prg_req = 1'b1;
      wait_done("t4_next_done", 1, 50, t1);
      chk("t4_next_err", err, 0);
      step();
      prg_req = 1'b0;
      chk("t4_next_rdata", prg_rdata, 16'h1234);

      // Reset in WAIT abandons the job silently.
      step();
      resp_lat = 3;
      chr_addr = 23'h000777; chr_req = 1'b1;
      wait_mreq("t5_mreq", t0);
      step();
      rst = 1'b1; chr_req = 1'b0;
      nd = 0; nb = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_mem);
         if (chr_done) nd++;
         if (i >= 1 && busy) nb++;
         step();
         if (i == 1) rst = 1'b0;
      end
      chk("t5_no_done", nd, 0);
      chk("t5_busy_after_rst", nb, 0);
      resp_lat = 1; rd_word = 16'hCAFE;
      step();
      chr_req = 1'b1;
      wait_done("t5_fresh_done", 0, 50, t1);
      step();
      chr_req = 1'b0;
      chk("t5_fresh_rdata", chr_rdata, 16'hCAFE);

      // Stray ready while idle, then a request dropped mid-transaction.
      step();
      stray_req_n++;
      repeat (4) step();
      chk("t6_stray_rdata", chr_rdata, 16'hCAFE);
      resp_lat = 4; rd_word = 16'h7777;
      chr_addr = 23'h000055; chr_req = 1'b1;
      wait_mreq("t6_mreq", t0);
      step();
      chr_req = 1'b0;
      wait_done("t6_dropped_done", 0, 50, t1);
      chk("t6_done_lat", t1 - t0, 5);
      step();
      chk("t6_rdata", chr_rdata, 16'h7777);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
